// File: rtl/dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter_if
// Description : One DMA request/response channel (address, data, handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_arbiter_if;
    logic [14:0] addr;
    logic [15:0] din;
    logic        en;
    logic [1:0]  we;
    logic        prio;
    logic [15:0] dout;
    logic        ready;
    logic        resp;

    // Requester side issues the access; responder side returns data/handshake.
    modport master (output addr, din, en, we, prio, input dout, ready, resp);
    modport slave  (input addr, din, en, we, prio, output dout, ready, resp);
endinterface
`default_nettype wire

// File: rtl/dma_arb_sel.sv
`default_nettype none
// ============================================================================
// Module      : dma_arb_sel
// Description : Combinational two-master selector (lock, priority, tie-break).
// Revision    : 1.0 - initial release
// ============================================================================
module dma_arb_sel #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  wire i_en0,
    input  wire i_en1,
    input  wire i_pri0,
    input  wire i_pri1,
    input  wire i_lock_vld,
    input  wire i_lock_id,
    input  wire i_rr_last,
    output logic o_sel_vld,
    output logic o_sel_id
);
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    logic w_lock_hold;

    // A locked master keeps the grant only while it still requests.
    assign w_lock_hold = i_lock_vld & ((i_lock_id == M1) ? i_en1 : i_en0);

    always_comb begin
        o_sel_vld = 1'b0;
        o_sel_id  = M0;
        if (w_lock_hold) begin
            o_sel_vld = 1'b1;
            o_sel_id  = i_lock_id;
        end else if (i_en0 && i_en1) begin
            o_sel_vld = 1'b1;
            if (i_pri0 != i_pri1) begin
                o_sel_id = i_pri1 ? M1 : M0;
            end else if (FIXED_PRIO != 0) begin
                o_sel_id = M0;
            end else begin
                o_sel_id = ~i_rr_last;
            end
        end else if (i_en0) begin
            o_sel_vld = 1'b1;
            o_sel_id  = M0;
        end else if (i_en1) begin
            o_sel_vld = 1'b1;
            o_sel_id  = M1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter
// Description : Merges two DMA masters onto the single openMSP430 DMA port.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  wire             mclk,
    input  wire             puc_rst,
    dma_arbiter_if.slave    m0,
    dma_arbiter_if.slave    m1,
    dma_arbiter_if.master   dma
);
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    logic r_lock_vld;
    logic r_lock_id;
    logic r_rr_last;
    logic r_own_vld;
    logic r_own_id;

    logic w_sel_vld_raw;
    logic w_sel_id;
    logic w_sel_vld;
    logic w_accept;
    logic w_ret0;
    logic w_ret1;

    dma_arb_sel #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_sel (
        .i_en0      (m0.en),
        .i_en1      (m1.en),
        .i_pri0     (m0.prio),
        .i_pri1     (m1.prio),
        .i_lock_vld (r_lock_vld),
        .i_lock_id  (r_lock_id),
        .i_rr_last  (r_rr_last),
        .o_sel_vld  (w_sel_vld_raw),
        .o_sel_id   (w_sel_id)
    );

    // Reset forces the core port idle at once, not just at the next edge.
    assign w_sel_vld = w_sel_vld_raw & ~puc_rst;
    assign w_accept  = w_sel_vld & dma.ready;

    assign dma.en   = w_sel_vld;
    assign dma.addr = !w_sel_vld ? 15'd0 : ((w_sel_id == M1) ? m1.addr : m0.addr);
    assign dma.din  = !w_sel_vld ? 16'd0 : ((w_sel_id == M1) ? m1.din  : m0.din);
    assign dma.we   = !w_sel_vld ? 2'd0  : ((w_sel_id == M1) ? m1.we   : m0.we);
    assign dma.prio = w_sel_vld & ((w_sel_id == M1) ? m1.prio : m0.prio);

    assign m0.ready = w_accept & (w_sel_id == M0);
    assign m1.ready = w_accept & (w_sel_id == M1);

    assign w_ret0  = r_own_vld & (r_own_id == M0);
    assign w_ret1  = r_own_vld & (r_own_id == M1);
    assign m0.dout = w_ret0 ? dma.dout : 16'd0;
    assign m1.dout = w_ret1 ? dma.dout : 16'd0;
    assign m0.resp = w_ret0 & dma.resp;
    assign m1.resp = w_ret1 & dma.resp;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= M0;
            r_rr_last  <= M0;
            r_own_vld  <= 1'b0;
            r_own_id   <= M0;
        end else begin
            r_own_vld <= w_accept;
            if (w_accept) begin
                r_rr_last  <= w_sel_id;
                r_own_id   <= w_sel_id;
                r_lock_vld <= 1'b0;
            end else if (w_sel_vld) begin
                // Stalled: pin the grant so the address cannot change under the core.
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_sel_id;
            end else begin
                r_lock_vld <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_arbiter
// Description : Directed self-checking bench for dma_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;
    logic mclk;
    logic puc_rst;
    int   n_assert;
    int   n_fail;

    dma_arbiter_if m0_if ();
    dma_arbiter_if m1_if ();
    dma_arbiter_if dma_if ();
    dma_arbiter_if fp_m0_if ();
    dma_arbiter_if fp_m1_if ();
    dma_arbiter_if fp_dma_if ();

    dma_arbiter #(.FIXED_PRIO(0)) u_dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .dma     (dma_if)
    );

    dma_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .m0      (fp_m0_if),
        .m1      (fp_m1_if),
        .dma     (fp_dma_if)
    );

    // Fixed-priority instance sees exactly the same stimulus.
    assign fp_m0_if.addr   = m0_if.addr;
    assign fp_m0_if.din    = m0_if.din;
    assign fp_m0_if.en     = m0_if.en;
    assign fp_m0_if.we     = m0_if.we;
    assign fp_m0_if.prio   = m0_if.prio;
    assign fp_m1_if.addr   = m1_if.addr;
    assign fp_m1_if.din    = m1_if.din;
    assign fp_m1_if.en     = m1_if.en;
    assign fp_m1_if.we     = m1_if.we;
    assign fp_m1_if.prio   = m1_if.prio;
    assign fp_dma_if.dout  = dma_if.dout;
    assign fp_dma_if.ready = dma_if.ready;
    assign fp_dma_if.resp  = dma_if.resp;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        puc_rst  = 1'b1;
        m0_if.addr = 15'd0; m0_if.din = 16'd0; m0_if.en = 1'b1; m0_if.we = 2'd0; m0_if.prio = 1'b0;
        m1_if.addr = 15'd0; m1_if.din = 16'd0; m1_if.en = 1'b0; m1_if.we = 2'd0; m1_if.prio = 1'b0;
        dma_if.dout = 16'h0; dma_if.ready = 1'b1; dma_if.resp = 1'b0;

        // Reset state: core port idle even with a request present.
        #2;
        check_val("rst_dma_en",   dma_if.en,   0);
        check_val("rst_dma_addr", dma_if.addr, 0);
        check_val("rst_m0_ready", m0_if.ready, 0);
        check_val("rst_m0_dout",  m0_if.dout,  0);
        step();
        m0_if.en = 1'b0;
        step();
        puc_rst = 1'b0;

        // Single master read of byte address 0x0100.
        step();
        m0_if.en = 1'b1; m0_if.addr = 15'h0080; dma_if.ready = 1'b1;
        #1;
        check_val("single_dma_en",   dma_if.en,   1);
        check_val("single_dma_addr", dma_if.addr, 15'h0080);
        check_val("single_dma_we",   dma_if.we,   0);
        check_val("single_m0_ready", m0_if.ready, 1);
        check_val("single_m1_ready", m1_if.ready, 0);
        step();
        m0_if.en = 1'b0; dma_if.dout = 16'hBEEF;
        #1;
        check_val("single_m0_dout", m0_if.dout, 16'hBEEF);
        check_val("single_m1_dout", m1_if.dout, 0);
        check_val("single_idle_en", dma_if.en,  0);
        step();
        #1;
        check_val("single_dout_clr", m0_if.dout, 0);

        // Round-robin contention: rr_last=0, so m1 wins first.
        m0_if.addr = 15'h0010; m1_if.addr = 15'h0020;
        m0_if.en = 1'b1; m1_if.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic exp_id;
            logic prev_id;
            exp_id  = (i % 2 == 0) ? 1'b1 : 1'b0;
            prev_id = ~exp_id;
            if (i == 4) begin
                m0_if.en = 1'b0; m1_if.en = 1'b0;
            end
            dma_if.dout = 16'hD000 + 16'(i);
            #1;
            if (i < 4) begin
                check_val($sformatf("rr_m0_ready_%0d", i), m0_if.ready, exp_id == 1'b0);
                check_val($sformatf("rr_m1_ready_%0d", i), m1_if.ready, exp_id == 1'b1);
                check_val($sformatf("rr_addr_%0d", i), dma_if.addr, exp_id ? 15'h0020 : 15'h0010);
                check_val($sformatf("fp_m0_ready_%0d", i), fp_m0_if.ready, 1);
            end
            if (i > 0) begin
                check_val($sformatf("rr_m0_dout_%0d", i), m0_if.dout, (prev_id == 1'b0) ? 16'hD000 + 16'(i) : 16'h0);
                check_val($sformatf("rr_m1_dout_%0d", i), m1_if.dout, (prev_id == 1'b1) ? 16'hD000 + 16'(i) : 16'h0);
            end
            step();
        end

        // Priority: m1 high priority wins every cycle until it drops.
        m0_if.en = 1'b1; m1_if.en = 1'b1; m1_if.prio = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("pri_m1_ready_%0d", i), m1_if.ready, 1);
            check_val($sformatf("pri_m0_ready_%0d", i), m0_if.ready, 0);
            check_val($sformatf("pri_dma_prio_%0d", i), dma_if.prio, 1);
            step();
        end
        m1_if.en = 1'b0; m1_if.prio = 1'b0;
        #1;
        check_val("pri_m0_after", m0_if.ready, 1);
        step();
        m0_if.en = 1'b0;

        // Lock: m0 stalled three cycles; m1 high priority must not pre-empt.
        m0_if.en = 1'b1; m0_if.addr = 15'h0111; dma_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m1_if.en = 1'b1; m1_if.prio = 1'b1; m1_if.addr = 15'h0222;
            end
            #1;
            check_val($sformatf("lock_addr_%0d", i), dma_if.addr, 15'h0111);
            check_val($sformatf("lock_m0_ready_%0d", i), m0_if.ready, 0);
            check_val($sformatf("lock_m1_ready_%0d", i), m1_if.ready, 0);
            step();
        end
        dma_if.ready = 1'b1;
        #1;
        check_val("lock_m0_accept", m0_if.ready, 1);
        check_val("lock_addr_acc",  dma_if.addr, 15'h0111);
        check_val("lock_fp_m0_acc", fp_m0_if.ready, 1);
        step();
        m0_if.en = 1'b0;
        #1;
        check_val("lock_m1_accept", m1_if.ready, 1);
        check_val("lock_addr_m1",   dma_if.addr, 15'h0222);
        step();
        m1_if.en = 1'b0; m1_if.prio = 1'b0;

        // Write with error response from the core.
        m1_if.en = 1'b1; m1_if.we = 2'b11; m1_if.din = 16'h1234; m1_if.addr = 15'h0100;
        dma_if.resp = 1'b0;
        #1;
        check_val("wr_dma_din",  dma_if.din,  16'h1234);
        check_val("wr_dma_we",   dma_if.we,   2'b11);
        check_val("wr_m1_ready", m1_if.ready, 1);
        step();
        m1_if.en = 1'b0; m1_if.we = 2'b00; dma_if.resp = 1'b1;
        #1;
        check_val("wr_m1_resp", m1_if.resp, 1);
        check_val("wr_m0_resp", m0_if.resp, 0);
        step();
        #1;
        check_val("wr_resp_clr", m1_if.resp, 0);
        dma_if.resp = 1'b0;

        // Reset during a return cycle; rr_last=1 before reset, 0 after.
        m1_if.en = 1'b1; m1_if.addr = 15'h0033;
        step();
        m1_if.en = 1'b1; m0_if.en = 1'b1;
        dma_if.dout = 16'h5555; dma_if.resp = 1'b1;
        #1;
        check_val("rstmid_m1_dout_pre", m1_if.dout, 16'h5555);
        check_val("rstmid_m0_ready_pre", m0_if.ready, 1);
        puc_rst = 1'b1;
        #1;
        check_val("rstmid_m1_dout", m1_if.dout,  0);
        check_val("rstmid_m1_resp", m1_if.resp,  0);
        check_val("rstmid_dma_en",  dma_if.en,   0);
        check_val("rstmid_m0_ready", m0_if.ready, 0);
        step();
        step();
        puc_rst = 1'b0;
        #1;
        check_val("post_rst_m1_ready", m1_if.ready, 1);
        check_val("post_rst_m0_ready", m0_if.ready, 0);
        step();
        m0_if.en = 1'b0; m1_if.en = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
